// File: rtl/trace_pkg.sv
// Shared types and helpers for the multi-channel trace capture buffer.
// The rep field in trace_entry_t exists only when TRACE_COMPRESS_EN is defined.
package trace_pkg;

  localparam int unsigned RD_ID_W   = 4;
  localparam int unsigned BEAT_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_e;

  // Entry layout for the default geometry: 4 channels, 40-bit stamp, 120-bit payload
  typedef struct packed {
    logic [39:0]  tstamp;
    logic [1:0]   ch;
`ifdef TRACE_COMPRESS_EN
    logic [15:0]  rep;
`endif
    logic [119:0] data;
  } trace_entry_t;

  function automatic int unsigned beats_for(int unsigned width);
    return (width + BEAT_BITS - 1) / BEAT_BITS;
  endfunction

endpackage

// File: rtl/trace_array_mc_if.sv
// Producer, control and MMIO read-back signals of trace_array_mc.
// master = the block driving samples/reads, slave = the trace array.
interface trace_array_mc_if import trace_pkg::*; #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 120,
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic [NUM_CH-1:0]            trace_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] trace_data;
  logic                         arm;
  logic                         trigger_in;
  logic [ADDR_WIDTH-1:0]        post_count;
  logic                         rd_req;
  logic [RD_ID_W-1:0]           rd_id;
  logic [BEAT_BITS-1:0]         rd_data;
  logic                         rd_ack;
  logic [1:0]                   state;
  logic                         wrapped;
  logic [15:0]                  drop_cnt;

  modport master (
    output trace_valid, trace_data, arm, trigger_in, post_count, rd_req, rd_id,
    input  rd_data, rd_ack, state, wrapped, drop_cnt
  );

  modport slave (
    input  trace_valid, trace_data, arm, trigger_in, post_count, rd_req, rd_id,
    output rd_data, rd_ack, state, wrapped, drop_cnt
  );

endinterface

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last granted channel,
// plus the number of other requesters that lost this cycle.
module trace_rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt_c,
  output logic [CH_W-1:0]   gnt_idx_c,
  output logic              gnt_any_c,
  output logic [CNT_W-1:0]  drop_c
);

  logic [CH_W-1:0]  ptr_q;
  logic [CH_W-1:0]  idx;
  logic [CNT_W-1:0] pop;

  // Scan from ptr_q upward (modulo NUM_CH); first requester wins
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    pop       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop = pop + CNT_W'(req[i]);
      idx = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_any_c && req[idx]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = idx;
      end
    end
    gnt_c[gnt_idx_c] = gnt_any_c;
    drop_c = gnt_any_c ? pop - CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (en && gnt_any_c) begin
      ptr_q <= (gnt_idx_c == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
    end
  end

endmodule

// File: rtl/trace_array_mc.sv
// Multi-channel trace capture buffer: arbitrated writes into a circular RAM,
// trigger/post-count stop, oldest-first 64-bit beat read-back. Option: TRACE_COMPRESS_EN.
module trace_array_mc import trace_pkg::*; #(
  parameter int unsigned        NUM_CH       = 4,
  parameter int unsigned        DATA_WIDTH   = 120,
  parameter int unsigned        ADDR_WIDTH   = 8,
  parameter int unsigned        TSTAMP_WIDTH = 40,
  parameter logic [RD_ID_W-1:0] TRACE_ID     = 4'h0
) (
  input logic             clk,
  input logic             reset,
  trace_array_mc_if.slave bus
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W   = $clog2(NUM_CH + 1);
`ifdef TRACE_COMPRESS_EN
  localparam int unsigned REP_W   = 16;
`else
  localparam int unsigned REP_W   = 0;
`endif
  localparam int unsigned ENTRY_W = TSTAMP_WIDTH + CH_W + REP_W + DATA_WIDTH;
  localparam int unsigned BEATS   = beats_for(ENTRY_W);
  localparam int unsigned PAD_W   = BEATS * BEAT_BITS;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;

  trace_state_e            state_q, state_d;
  logic [TSTAMP_WIDTH-1:0] ts_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q, post_tgt_q, post_done_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    wrapped_q;
  logic [15:0]             drop_q;
  logic [BEAT_BITS-1:0]    rd_data_q;
  logic                    rd_ack_q;
  logic [ENTRY_W-1:0]      mem [DEPTH];

  logic                    capturing_c, wr_en_c, repeat_c, match_c, stop_entry_c, wrap_nx_c;
  logic [ADDR_WIDTH-1:0]   wr_ptr_nx_c;
  logic [NUM_CH-1:0]       gnt_c;
  logic [CH_W-1:0]         gnt_idx_c;
  logic                    gnt_any_c;
  logic [CNT_W-1:0]        drop_c;
  logic [16:0]             drop_sum_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;
  logic [ENTRY_W-1:0]      entry_c;
  logic [PAD_W-1:0]        padded_c;
  logic [BEAT_BITS-1:0]    beat_c;

  assign capturing_c = ((state_q == ST_CAPTURE) || (state_q == ST_POST)) && !bus.arm;
  assign match_c     = bus.rd_req && (bus.rd_id == TRACE_ID);

  trace_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (capturing_c),
    .req       (bus.trace_valid),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c),
    .drop_c    (drop_c)
  );

  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_c[i]) sel_data_c = bus.trace_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef TRACE_COMPRESS_EN
  logic [DATA_WIDTH-1:0] last_data_q [NUM_CH];
  logic [NUM_CH-1:0]     last_vld_q;
  logic [15:0]           rep_q [NUM_CH];

  assign repeat_c = last_vld_q[gnt_idx_c] && (last_data_q[gnt_idx_c] == sel_data_c);
  assign entry_c  = {ts_q, gnt_idx_c, rep_q[gnt_idx_c], sel_data_c};

  // Per-channel last written payload and suppressed-repeat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        last_data_q[i] <= '0;
        rep_q[i]       <= '0;
      end
    end else if (bus.arm) begin
      last_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) rep_q[i] <= '0;
    end else if (capturing_c && gnt_any_c) begin
      if (repeat_c) begin
        if (rep_q[gnt_idx_c] != 16'hFFFF) rep_q[gnt_idx_c] <= rep_q[gnt_idx_c] + 16'd1;
      end else begin
        last_data_q[gnt_idx_c] <= sel_data_c;
        last_vld_q[gnt_idx_c]  <= 1'b1;
        rep_q[gnt_idx_c]       <= '0;
      end
    end
  end
`else
  assign repeat_c = 1'b0;
  assign entry_c  = {ts_q, gnt_idx_c, sel_data_c};
`endif

  assign wr_en_c     = capturing_c && gnt_any_c && !repeat_c;
  assign wr_ptr_nx_c = wr_en_c ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
  assign wrap_nx_c   = wrapped_q || (wr_en_c && (&wr_ptr_q));
  assign drop_sum_c  = 17'(drop_q) + 17'(drop_c);

  // Next state; arm overrides everything including a same-cycle trigger
  always_comb begin
    state_d      = state_q;
    stop_entry_c = 1'b0;
    if (bus.arm) begin
      state_d = ST_CAPTURE;
    end else begin
      case (state_q)
        ST_CAPTURE: if (bus.trigger_in) state_d = (bus.post_count == '0) ? ST_STOPPED : ST_POST;
        ST_POST:    if (wr_en_c && (post_done_q + ADDR_WIDTH'(1) == post_tgt_q)) state_d = ST_STOPPED;
        default:    state_d = state_q;
      endcase
      stop_entry_c = (state_d == ST_STOPPED) && (state_q != ST_STOPPED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Entry is left-aligned in the beat frame so the last beat pads at the LSBs
  always_comb begin
    padded_c = PAD_W'(mem[rd_ptr_q]) << (PAD_W - ENTRY_W);
    beat_c   = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) beat_c = padded_c[PAD_W-1-b*BEAT_BITS -: BEAT_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= entry_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      beat_q      <= '0;
      post_tgt_q  <= '0;
      post_done_q <= '0;
      wrapped_q   <= 1'b0;
      drop_q      <= '0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      ts_q     <= ts_q + TSTAMP_WIDTH'(1);
      rd_ack_q <= match_c;
      if (match_c) rd_data_q <= beat_c;
      if (bus.arm) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        beat_q      <= '0;
        post_done_q <= '0;
        wrapped_q   <= 1'b0;
        drop_q      <= '0;
      end else begin
        wr_ptr_q  <= wr_ptr_nx_c;
        wrapped_q <= wrap_nx_c;
        if (capturing_c && gnt_any_c) drop_q <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
        if ((state_q == ST_CAPTURE) && bus.trigger_in) begin
          post_tgt_q  <= bus.post_count;
          post_done_q <= '0;
        end else if ((state_q == ST_POST) && wr_en_c) begin
          post_done_q <= post_done_q + ADDR_WIDTH'(1);
        end
        // Read start snaps to the oldest entry when capture stops
        if (stop_entry_c) begin
          rd_ptr_q <= wrap_nx_c ? wr_ptr_nx_c : '0;
          beat_q   <= '0;
        end else if (match_c) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_q   <= '0;
            rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
      end
    end
  end

  assign bus.state    = state_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.drop_cnt = drop_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ack   = rd_ack_q;

endmodule

// File: tb/tb_trace_array_mc.sv
// Randomized bench for trace_array_mc against a behavioural capture/read model.
// Scenario 6 runs when TRACE_COMPRESS_EN is defined.
module tb_trace_array_mc;
  import trace_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW     = 120;
  localparam int unsigned AW     = 4;
  localparam int unsigned TSW    = 40;
  localparam int unsigned CH_W   = 2;
`ifdef TRACE_COMPRESS_EN
  localparam int unsigned REP_W  = 16;
`else
  localparam int unsigned REP_W  = 0;
`endif
  localparam int unsigned ENTRY_W = TSW + CH_W + REP_W + DW;
  localparam int unsigned BEATS   = (ENTRY_W + 63) / 64;
  localparam int unsigned FRAME_W = BEATS * 64;
  localparam int unsigned PADB    = FRAME_W - ENTRY_W;
  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [3:0]  TID     = 4'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  trace_array_mc_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  trace_array_mc #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TSTAMP_WIDTH(TSW), .TRACE_ID(TID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state as plain integers, RAM as an array of whole entries
  logic [TSW-1:0]     m_ts;
  int                 m_state, m_wr, m_drop, m_rr, m_tgt, m_done, m_rd, m_beat;
  bit                 m_wrapped;
  logic [ENTRY_W-1:0] m_mem [DEPTH];
  bit                 m_vld [DEPTH];
  logic [DW-1:0]      m_last [NUM_CH];
  bit                 m_lastv [NUM_CH];
  int                 m_rep [NUM_CH];
  bit                 e_ack, e_known;
  logic [63:0]        e_data;

  task automatic model_reset();
    m_ts = '0; m_state = 0; m_wr = 0; m_drop = 0; m_rr = 0; m_tgt = 0; m_done = 0;
    m_rd = 0; m_beat = 0; m_wrapped = 0; e_ack = 0; e_known = 0; e_data = '0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    for (int i = 0; i < NUM_CH; i++) begin m_lastv[i] = 0; m_rep[i] = 0; m_last[i] = '0; end
  endtask

  task automatic model_step();
    int n, w, c;
    bit wrote, stop;
    logic [DW-1:0] d;
    logic [FRAME_W-1:0] p;
    if (reset) begin model_reset(); return; end
    e_ack = 0;
    if (bus.rd_req && bus.rd_id == TID) begin
      e_ack = 1;
      e_known = m_vld[m_rd];
      p = '0;
      p[FRAME_W-1 -: ENTRY_W] = m_mem[m_rd];
      e_data = p[FRAME_W-1-m_beat*64 -: 64];
      m_beat++;
      if (m_beat == BEATS) begin m_beat = 0; m_rd = (m_rd + 1) % DEPTH; end
    end
    if (bus.arm) begin
      m_state = 1; m_wr = 0; m_wrapped = 0; m_drop = 0; m_rd = 0; m_beat = 0; m_done = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_lastv[i] = 0; m_rep[i] = 0; end
    end else if (m_state == 1 || m_state == 2) begin
      n = 0; w = -1; wrote = 0; stop = 0;
      for (int i = 0; i < NUM_CH; i++) if (bus.trace_valid[i]) n++;
      for (int i = 0; i < NUM_CH; i++) begin
        c = (m_rr + i) % NUM_CH;
        if (w < 0 && bus.trace_valid[c]) w = c;
      end
      if (w >= 0) begin
        m_drop += n - 1;
        if (m_drop > 65535) m_drop = 65535;
        m_rr = (w + 1) % NUM_CH;
        d = bus.trace_data[w*DW +: DW];
`ifdef TRACE_COMPRESS_EN
        if (m_lastv[w] && m_last[w] == d) begin
          if (m_rep[w] < 65535) m_rep[w]++;
        end else begin
          m_mem[m_wr % DEPTH] = {m_ts, 2'(w), 16'(m_rep[w]), d};
          m_rep[w] = 0; m_last[w] = d; m_lastv[w] = 1; wrote = 1;
        end
`else
        m_mem[m_wr % DEPTH] = {m_ts, 2'(w), d};
        wrote = 1;
`endif
        if (wrote) begin
          m_vld[m_wr % DEPTH] = 1;
          m_wr++;
          if (m_wr % DEPTH == 0) m_wrapped = 1;
        end
      end
      if (m_state == 1 && bus.trigger_in) begin
        if (bus.post_count == 0) stop = 1;
        else begin m_state = 2; m_tgt = int'(bus.post_count); m_done = 0; end
      end else if (m_state == 2 && wrote) begin
        m_done++;
        if (m_done == m_tgt) stop = 1;
      end
      if (stop) begin
        m_state = 3; m_beat = 0;
        m_rd = m_wrapped ? (m_wr % DEPTH) : 0;
      end
    end
    m_ts++;
  endtask

  task automatic compare_all();
    check("state", 64'(bus.state), 64'(m_state));
    check("wrapped", 64'(bus.wrapped), 64'(m_wrapped));
    check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    check("rd_ack", 64'(bus.rd_ack), 64'(e_ack));
    if (e_ack && e_known) check("rd_data", bus.rd_data, e_data);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    bus.trace_valid = '0; bus.trace_data = '0; bus.arm = 0; bus.trigger_in = 0;
    bus.post_count = '0; bus.rd_req = 0; bus.rd_id = TID;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    cycle(); cycle();
    reset = 0;
  endtask

  task automatic arm_pulse();
    clear_in(); bus.arm = 1; cycle(); bus.arm = 0;
  endtask

  task automatic stop_now();
    clear_in(); bus.trigger_in = 1; bus.post_count = '0; cycle(); clear_in();
  endtask

  task automatic read_entry(output logic [ENTRY_W-1:0] ent);
    logic [FRAME_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < BEATS; b++) begin
      bus.rd_req = 1; bus.rd_id = TID; cycle();
      acc = {acc[FRAME_W-65:0], bus.rd_data};
    end
    bus.rd_req = 0;
    ent = acc[FRAME_W-1 -: ENTRY_W];
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  logic [ENTRY_W-1:0] ent;
  trace_entry_t       te;
  logic [DW-1:0]      hist [32];

  initial begin
    clear_in();
    do_reset();

    // 1: three ch0 samples, immediate stop, oldest-first readback
    arm_pulse();
    for (int i = 1; i <= 3; i++) begin
      bus.trace_valid = 4'b0001; bus.trace_data = '0; bus.trace_data[DW-1:0] = DW'(i); cycle();
    end
    stop_now();
    cycle();
    check("t1_state", 64'(bus.state), 64'(3));
    read_entry(ent);
    check("t1_oldest_lsb", bus.rd_data >> PADB, 64'h1);
    te = ent;
    check("t1_oldest_data", 64'(te.data), 64'h1);
    read_entry(ent); read_entry(ent);

    // 2: all channels valid for four cycles from a fresh RR pointer
    do_reset();
    arm_pulse();
    for (int i = 0; i < 4; i++) begin
      bus.trace_valid = 4'hF;
      for (int k = 0; k < NUM_CH; k++) bus.trace_data[k*DW +: DW] = rnd_data();
      cycle();
    end
    clear_in(); cycle();
    check("t2_drop", 64'(bus.drop_cnt), 64'd12);
    stop_now();
    for (int i = 0; i < 4; i++) begin
      read_entry(ent); te = ent;
      check("t2_grant_ch", 64'(te.ch), 64'(i));
    end

    // 3: wrap a 16-deep RAM, trigger, two post writes
    arm_pulse();
    for (int i = 1; i <= 22; i++) begin
      if (i == 21) begin
        clear_in(); bus.trigger_in = 1; bus.post_count = AW'(2); cycle(); clear_in();
      end
      hist[i] = rnd_data();
      bus.trace_valid = 4'(1 << $urandom_range(0, 3));
      for (int k = 0; k < NUM_CH; k++) bus.trace_data[k*DW +: DW] = hist[i];
      cycle();
    end
    clear_in(); cycle();
    check("t3_state", 64'(bus.state), 64'(3));
    check("t3_wrapped", 64'(bus.wrapped), 64'(1));
    read_entry(ent); te = ent;
    check("t3_first_is_w7", 64'(te.data), 64'(hist[7]));
    for (int i = 1; i < DEPTH; i++) read_entry(ent);

    // 4: foreign trace id is ignored
    bus.rd_req = 1; bus.rd_id = 4'h5; cycle(); clear_in();
    check("t4_no_ack", 64'(bus.rd_ack), 64'(0));
    read_entry(ent); te = ent;
    check("t4_ptr_kept", 64'(te.data), 64'(hist[7]));

    // 5: arm beats a simultaneous trigger; async reset during POST
    clear_in(); bus.arm = 1; bus.trigger_in = 1; bus.post_count = AW'(5); cycle(); clear_in();
    check("t5_state", 64'(bus.state), 64'(1));
    bus.trace_valid = 4'b0100; bus.trace_data[2*DW +: DW] = rnd_data(); cycle(); clear_in();
    read_entry(ent);
    bus.trigger_in = 1; bus.post_count = AW'(3); cycle(); clear_in();
    bus.trace_valid = 4'b0010; bus.trace_data[DW +: DW] = rnd_data(); cycle(); clear_in();
    check("t5_post", 64'(bus.state), 64'(2));
    reset = 1;
    #1;
    check("t5_async_reset", 64'(bus.state), 64'(0));
    cycle(); cycle();
    reset = 0;

`ifdef TRACE_COMPRESS_EN
    // 6: repeated samples collapse into a rep count
    arm_pulse();
    for (int i = 0; i < 6; i++) begin
      bus.trace_valid = 4'b0010; bus.trace_data[DW +: DW] = (i < 5) ? DW'('hA) : DW'('hB); cycle();
    end
    stop_now();
    read_entry(ent); te = ent;
    check("t6_a_rep", 64'(te.rep), 64'(0));
    read_entry(ent); te = ent;
    check("t6_b_data", 64'(te.data), 64'hB);
    check("t6_b_rep", 64'(te.rep), 64'(4));
`endif

    // 7: random traffic, triggers, re-arms and interleaved reads
    arm_pulse();
    for (int t = 0; t < 600; t++) begin
      bus.trace_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      for (int k = 0; k < NUM_CH; k++) bus.trace_data[k*DW +: DW] = DW'($urandom_range(1, 3));
      bus.trigger_in = ($urandom_range(0, 29) == 0);
      bus.post_count = AW'($urandom_range(0, 5));
      bus.arm = (m_state == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
      bus.rd_req = ($urandom_range(0, 2) == 0);
      bus.rd_id = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : TID;
      cycle();
    end
    clear_in(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
